// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state encoding,
// load-op encodings, reset PC and the forwarding bundle widths.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } ms_state_e;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

    localparam int RF_WE_W   = 4;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the returned
// word and sign- or zero-extends it. Instantiated only under MEM_LOAD_EXT_EN.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_op,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (ld_op)
            LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data = {24'd0, byte_sel};
            LD_H:    data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, runs its data-SRAM transaction
// (req/addr_ok/data_ok) and forwards its result to ID. Optional: MEM_LOAD_EXT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allow_in,
    input  logic [DATA_W-1:0]    es_pc,
    input  logic [DATA_W-1:0]    es_alu_result,
    input  logic                 es_sram_en,
    input  logic [3:0]           es_sram_we,
    input  logic [DATA_W-1:0]    es_store_data,
    input  logic [2:0]           es_ld_op,
    input  logic [RF_WE_W-1:0]   es_rf_we,
    input  logic [RF_ADDR_W-1:0] es_rf_waddr,
    output logic                 data_sram_req,
    output logic                 data_sram_wr,
    output logic [3:0]           data_sram_wstrb,
    output logic [DATA_W-1:0]    data_sram_addr,
    output logic [DATA_W-1:0]    data_sram_wdata,
    input  logic                 data_sram_addr_ok,
    input  logic                 data_sram_data_ok,
    input  logic [DATA_W-1:0]    data_sram_rdata,
    output logic                 ms_to_ws_valid,
    input  logic                 ws_allow_in,
    output logic [DATA_W-1:0]    ms_pc,
    output logic [RF_WE_W-1:0]   ms_rf_we,
    output logic [RF_ADDR_W-1:0] ms_rf_waddr,
    output logic [DATA_W-1:0]    ms_rf_wdata,
    output logic                 ms_ld_pending
);

    ms_state_e state_reg, state_next;

    logic                 ms_valid_reg;
    logic [DATA_W-1:0]    pc_reg;
    logic [DATA_W-1:0]    alu_result_reg;
    logic                 load_reg;
    logic [3:0]           sram_we_reg;
    logic [DATA_W-1:0]    store_data_reg;
    logic                 is_mem_reg;
    logic [RF_WE_W-1:0]   rf_we_reg;
    logic [RF_ADDR_W-1:0] rf_waddr_reg;
    logic [DATA_W-1:0]    ld_buf_reg;

    logic              ms_ready_go;
    logic              load_fire;
    logic              es_is_mem;
    logic              ld_capture;
    logic [DATA_W-1:0] ld_data;

    assign es_is_mem   = es_sram_en | (|es_sram_we);
    assign ms_ready_go = ms_valid_reg && (!is_mem_reg || state_reg == ST_DONE);
    assign ms_allow_in = !ms_valid_reg || (ms_ready_go && ws_allow_in);
    assign load_fire   = es_to_ms_valid && ms_allow_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid_reg   <= 1'b0;
            pc_reg         <= RESET_PC;
            alu_result_reg <= '0;
            load_reg       <= 1'b0;
            sram_we_reg    <= '0;
            store_data_reg <= '0;
            is_mem_reg     <= 1'b0;
            rf_we_reg      <= '0;
            rf_waddr_reg   <= '0;
        end else begin
            if (ms_allow_in) begin
                ms_valid_reg <= es_to_ms_valid;
            end
            if (load_fire) begin
                pc_reg         <= es_pc;
                alu_result_reg <= es_alu_result;
                load_reg       <= es_sram_en;
                sram_we_reg    <= es_sram_we;
                store_data_reg <= es_store_data;
                is_mem_reg     <= es_is_mem;
                rf_we_reg      <= es_rf_we;
                rf_waddr_reg   <= es_rf_waddr;
            end
        end
    end

    // Only one transaction is ever outstanding; DONE doubles as the
    // "result ready" hold state while WB back-pressures.
    always_comb begin
        state_next = state_reg;
        ld_capture = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load_fire && es_is_mem) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (data_sram_addr_ok) begin
                    if (data_sram_data_ok) begin
                        state_next = ST_DONE;
                        ld_capture = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_sram_data_ok) begin
                    state_next = ST_DONE;
                    ld_capture = 1'b1;
                end
            end
            ST_DONE: begin
                if (ws_allow_in) begin
                    state_next = (load_fire && es_is_mem) ? ST_REQ : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            ld_buf_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (ld_capture) ld_buf_reg <= data_sram_rdata;
        end
    end

`ifdef MEM_LOAD_EXT_EN
    logic [2:0] ld_op_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_op_reg <= LD_W;
        end else if (load_fire) begin
            ld_op_reg <= es_ld_op;
        end
    end

    mem_stage_load_align u_load_align (
        .word    (ld_buf_reg),
        .addr_lo (alu_result_reg[1:0]),
        .ld_op   (ld_op_reg),
        .data    (ld_data)
    );
`else
    logic unused_ld_op;
    assign unused_ld_op = ^es_ld_op;
    assign ld_data      = ld_buf_reg;
`endif

    assign data_sram_req   = ms_valid_reg && (state_reg == ST_REQ);
    assign data_sram_wr    = |sram_we_reg;
    assign data_sram_wstrb = sram_we_reg;
    assign data_sram_addr  = alu_result_reg;
    assign data_sram_wdata = store_data_reg;

    assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
    assign ms_pc          = pc_reg;
    assign ms_rf_we       = {RF_WE_W{ms_valid_reg}} & rf_we_reg;
    assign ms_rf_waddr    = rf_waddr_reg;
    assign ms_rf_wdata    = load_reg ? ld_data : alu_result_reg;
    assign ms_ld_pending  = ms_valid_reg && load_reg && (state_reg != ST_DONE);

endmodule
